// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared constants, state type and helpers for the 4-way round-robin
// arbiter/mux (mux_rr_arbiter_4) and its priority picker (rr_pick_4).
//   C_NUM_REQ   : number of requesters
//   C_SEL_W     : width of a requester index
//   t_arb_state : output-buffer state (empty / holding a word)
//   next_rr()   : wrap-around increment of a requester index
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int C_SEL_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } t_arb_state;

    // Index following 'last' in round-robin order; 3 wraps to 0.
    function automatic logic [C_SEL_W-1:0] next_rr(input logic [C_SEL_W-1:0] last);
        return last + C_SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// -----------------------------------------------------------------------------
// rr_pick_4
// Combinational round-robin picker. Searches the request vector starting at
// the index after i_Last and wrapping, and returns the first set request.
// Ports:
//   i_Req   [3:0] : request vector (already masked by the caller if needed)
//   i_Last  [1:0] : index of the most recent grant (lowest priority now)
//   o_Grant [3:0] : one-hot grant, all zero when no request
//   o_Index [1:0] : index of the granted requester (0 when none)
//   o_Any         : at least one request present
// -----------------------------------------------------------------------------
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [C_NUM_REQ-1:0] i_Req,
    input  logic [C_SEL_W-1:0]   i_Last,
    output logic [C_NUM_REQ-1:0] o_Grant,
    output logic [C_SEL_W-1:0]   o_Index,
    output logic                 o_Any
);

    logic [C_SEL_W-1:0] cand;
    logic               found;

    always_comb begin
        cand    = '0;
        found   = 1'b0;
        o_Index = '0;
        // Priority order: i_Last+1, i_Last+2, i_Last+3, i_Last (all mod 4).
        for (int j = 0; j < C_NUM_REQ; j++) begin
            cand = next_rr(i_Last) + C_SEL_W'(j);
            if (!found && i_Req[cand]) begin
                found   = 1'b1;
                o_Index = cand;
            end
        end
        o_Any   = found;
        o_Grant = found ? (C_NUM_REQ'(1) << o_Index) : '0;
    end

endmodule

// File: rtl/mux_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_4
// Shares one g_WIDTH-bit output channel between 4 requesters. Each accept
// slot a round-robin winner is chosen, its word is selected by a 4:1 mux and
// registered into a 1-entry output buffer. Valid/ready on both sides; a full
// buffer being drained can accept a new word on the same edge (1 word/cycle).
//
// Optional feature (macro MUX_RR_ARBITER_LOCK_EN): adds i_Lock[3:0]. A
// transfer from k with i_Lock[k]=1 locks the arbiter to k until a transfer
// from k with i_Lock[k]=0.
//
// Ports:
//   i_Clk, i_Reset        : clock, synchronous active-high reset
//   i_Valid [3:0]         : per-requester valid
//   i_Data1..i_Data4      : data of requesters 0..3
//   i_Lock  [3:0]         : lock request per requester (lock build only)
//   o_Ready [3:0]         : one-hot accept strobe (combinational)
//   o_Valid               : buffer holds a word
//   o_Data                : buffered word
//   o_Select [1:0]        : requester index of the buffered word
//   i_Ready               : downstream accepts o_Data this cycle
// -----------------------------------------------------------------------------
module mux_rr_arbiter_4
    import mux_arb_pkg::*;
#(
    parameter int g_WIDTH = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [C_NUM_REQ-1:0] i_Valid,
    input  logic [g_WIDTH-1:0]   i_Data1,
    input  logic [g_WIDTH-1:0]   i_Data2,
    input  logic [g_WIDTH-1:0]   i_Data3,
    input  logic [g_WIDTH-1:0]   i_Data4,
`ifdef MUX_RR_ARBITER_LOCK_EN
    input  logic [C_NUM_REQ-1:0] i_Lock,
`endif
    output logic [C_NUM_REQ-1:0] o_Ready,
    output logic                 o_Valid,
    output logic [g_WIDTH-1:0]   o_Data,
    output logic [C_SEL_W-1:0]   o_Select,
    input  logic                 i_Ready
);

    t_arb_state           state_q, state_d;
    logic [C_SEL_W-1:0]   last_q;
    logic [g_WIDTH-1:0]   data_q;
    logic [C_SEL_W-1:0]   sel_q;

    logic [C_NUM_REQ-1:0] req_elig;
    logic [C_NUM_REQ-1:0] pick_grant;
    logic [C_SEL_W-1:0]   pick_idx;
    logic                 pick_any;
    logic                 slot;
    logic                 load;
    logic [g_WIDTH-1:0]   mux_data;

`ifdef MUX_RR_ARBITER_LOCK_EN
    logic                 lock_q;
    logic [C_SEL_W-1:0]   lock_own_q;

    // While locked only the owner may compete, even if it is not requesting.
    assign req_elig = lock_q ? (i_Valid & (C_NUM_REQ'(1) << lock_own_q)) : i_Valid;
`else
    assign req_elig = i_Valid;
`endif

    rr_pick_4 u_pick (
        .i_Req   (req_elig),
        .i_Last  (last_q),
        .o_Grant (pick_grant),
        .o_Index (pick_idx),
        .o_Any   (pick_any)
    );

    // A slot exists when the buffer is empty or is being drained this cycle.
    assign slot = (state_q == ST_IDLE) || ((state_q == ST_FULL) && i_Ready);
    assign load = slot && pick_any && !i_Reset;

    always_comb begin
        case (pick_idx)
            2'd0:    mux_data = i_Data1;
            2'd1:    mux_data = i_Data2;
            2'd2:    mux_data = i_Data3;
            default: mux_data = i_Data4;
        endcase
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_FULL;
            ST_FULL: if (i_Ready && !load) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_Ready  = load ? pick_grant : '0;
        o_Valid  = (state_q == ST_FULL);
        o_Data   = data_q;
        o_Select = sel_q;
    end

    // Buffer and round-robin pointer; both only move on a transfer in.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            data_q <= '0;
            sel_q  <= '0;
            last_q <= C_SEL_W'(C_NUM_REQ - 1);
        end else if (load) begin
            data_q <= mux_data;
            sel_q  <= pick_idx;
            last_q <= pick_idx;
        end
    end

`ifdef MUX_RR_ARBITER_LOCK_EN
    // Only the owner can transfer while locked, so the new lock state is
    // simply the lock bit presented with the accepted word.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            lock_q     <= 1'b0;
            lock_own_q <= '0;
        end else if (load) begin
            lock_q     <= i_Lock[pick_idx];
            lock_own_q <= pick_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
module tb_mux_rr_arbiter_4;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [3:0] i_Valid;
    logic [7:0] d [4];
    logic [3:0] o_Ready;
    logic       o_Valid;
    logic [7:0] o_Data;
    logic [1:0] o_Select;
    logic       i_Ready;
`ifdef MUX_RR_ARBITER_LOCK_EN
    logic [3:0] i_Lock = 4'b0000;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: what the output buffer and priority pointer should be.
    int       m_last;
    bit       m_bufv;
    int       m_data;
    int       m_sel;
    int       m_acc;     // requester accepted in the last cycle, -1 if none

    always #5 i_Clk = ~i_Clk;

    mux_rr_arbiter_4 #(.g_WIDTH(8)) dut (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Valid  (i_Valid),
        .i_Data1  (d[0]),
        .i_Data2  (d[1]),
        .i_Data3  (d[2]),
        .i_Data4  (d[3]),
`ifdef MUX_RR_ARBITER_LOCK_EN
        .i_Lock   (i_Lock),
`endif
        .o_Ready  (o_Ready),
        .o_Valid  (o_Valid),
        .o_Data   (o_Data),
        .o_Select (o_Select),
        .i_Ready  (i_Ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First requester found scanning from the one after 'last', wrapping.
    function automatic int mdl_pick(input logic [3:0] v, input int last);
        for (int j = 1; j <= 4; j++) begin
            int k = (last + j) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check the combinational accept strobe against the model,
    // advance the model across the edge, then check the registered outputs.
    task automatic cycle();
        int w;
        bit slot;
        logic [3:0] exp_rdy;
        #1;
        slot = !m_bufv || i_Ready;
        w    = mdl_pick(i_Valid, m_last);
        exp_rdy = (!i_Reset && slot && w >= 0) ? (4'b0001 << w) : 4'b0000;
        check_eq("o_Ready", o_Ready, exp_rdy);
        @(posedge i_Clk);
        m_acc = -1;
        if (i_Reset) begin
            m_bufv = 0; m_data = 0; m_sel = 0; m_last = 3;
        end else begin
            if (m_bufv && i_Ready) m_bufv = 0;
            if (slot && w >= 0) begin
                m_bufv = 1; m_data = d[w]; m_sel = w; m_last = w; m_acc = w;
            end
        end
        #1;
        check_eq("o_Valid", o_Valid, m_bufv);
        check_eq("o_Data", o_Data, m_data);
        check_eq("o_Select", o_Select, m_sel);
    endtask

    task automatic do_reset(input int n);
        i_Reset = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        i_Reset = 1'b0;
    endtask

    initial begin
        i_Reset = 1'b1; i_Valid = 4'b1111; i_Ready = 1'b0;
        d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
        m_last = 3; m_bufv = 0; m_data = 0; m_sel = 0; m_acc = -1;
        @(posedge i_Clk); #1;

        // Reset held 2 cycles with every requester asking.
        do_reset(2);
        check_eq("rst_valid", o_Valid, 1'b0);
        check_eq("rst_data", o_Data, 8'h00);
        #1;
        check_eq("first_grant", o_Ready, 4'b0001);

        // All requesting, downstream always ready: 0,1,2,3,0 back to back.
        i_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("fair_sel", o_Select, i % 4);
            check_eq("fair_data", o_Data, 8'hA0 + (i % 4));
            check_eq("fair_valid", o_Valid, 1'b1);
        end

        // Backpressure: requester 2 sends 5C, downstream stalls 5 cycles.
        do_reset(1);
        i_Valid = 4'b0100; d[2] = 8'h5C; i_Ready = 1'b0;
        cycle();
        i_Valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("bp_ready", o_Ready, 4'b0000);
            check_eq("bp_data", o_Data, 8'h5C);
            check_eq("bp_sel", o_Select, 2'd2);
        end
        i_Ready = 1'b1;
        #1;
        check_eq("bp_release_grant", o_Ready, 4'b1000);
        cycle();
        check_eq("bp_release_sel", o_Select, 2'd3);
        check_eq("bp_release_valid", o_Valid, 1'b1);

        // Wrap and skip.
        do_reset(1);
        i_Valid = 4'b1000; cycle();
        i_Valid = 4'b0100; cycle();
        check_eq("skip_sel2", o_Select, 2'd2);
        i_Valid = 4'b1001; cycle();
        check_eq("wrap_sel3", o_Select, 2'd3);
        i_Valid = 4'b0001; cycle();
        check_eq("wrap_sel0", o_Select, 2'd0);
        i_Valid = 4'b0000; cycle();
        check_eq("drain_valid", o_Valid, 1'b0);
        check_eq("drain_hold_sel", o_Select, 2'd0);

        // Reset while a word is stalled in the buffer: it is never delivered.
        i_Valid = 4'b0010; d[1] = 8'h77; i_Ready = 1'b0;
        cycle();
        i_Valid = 4'b0000;
        check_eq("mid_loaded", o_Data, 8'h77);
        do_reset(1);
        check_eq("mid_rst_valid", o_Valid, 1'b0);
        check_eq("mid_rst_data", o_Data, 8'h00);
        i_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("mid_no_deliver", o_Valid, 1'b0);
        end

        // Randomized traffic: requests held until accepted (occasionally
        // withdrawn), random backpressure, occasional reset.
        i_Valid = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            if (m_acc >= 0) i_Valid[m_acc] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!i_Valid[k] && $urandom_range(0, 1) == 1) begin
                    i_Valid[k] = 1'b1;
                    d[k] = 8'($urandom);
                end else if (i_Valid[k] && $urandom_range(0, 15) == 0) begin
                    i_Valid[k] = 1'b0;
                end
            end
            i_Ready = ($urandom_range(0, 9) < 7);
            i_Reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        i_Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
